// File: rtl/morse_entry_ctrl.sv
// morse_entry_ctrl
//   Sequencing controller for the Morse-to-text datapath. Debounced
//   dot/dash pulses build a symbol (first symbol in bit 0, 1 = dash). A
//   commit hands the symbol to the external glyph decoder over a req/ack
//   handshake. The returned glyph goes into an 8-slot character buffer,
//   and that buffer is scanned onto an 8-digit seven-segment display.
//
// Ports
//   clock, reset_n      system clock, asynchronous active-low reset
//   dot_pulse           append a dot            (single-cycle pulse)
//   dash_pulse          append a dash           (single-cycle pulse)
//   commit_pulse        end of character        (single-cycle pulse)
//   bksp_pulse          backspace               (single-cycle pulse)
//   decode_req  (out)   level request to the decoder; high for the whole DECODE state
//   decode_ack  (in)    decoder response valid; glyph is sampled in this cycle
//   glyph       (in)    {g,f,e,d,c,b,a} active-low; 7'h7F means unknown code
//   sym_bits, sym_len   symbol under construction / being decoded
//   busy                high in DECODE; this is also the FSM state observation point
//   char_count          occupied buffer slots, 0..8
//   sym_err             sticky flag: more than MAX_SYM symbols were entered
//   anode, out          active-low digit enable (anode[7] = slot 0) and segments
//
// Handshake: decode_req rises the cycle after an accepted commit and stays
// high until the cycle in which decode_ack=1 is seen. That cycle completes
// the transfer. decode_ack outside DECODE is ignored.

module morse_entry_ctrl #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned MAX_SYM  = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       dot_pulse,
  input  logic       dash_pulse,
  input  logic       commit_pulse,
  input  logic       bksp_pulse,
  input  logic       decode_ack,
  input  logic [6:0] glyph,
  output logic       decode_req,
  output logic [4:0] sym_bits,
  output logic [2:0] sym_len,
  output logic       busy,
  output logic [3:0] char_count,
  output logic       sym_err,
  output logic [7:0] anode,
  output logic [6:0] out
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;

  typedef enum logic {COLLECT = 1'b0, DECODE = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [4:0] sym_bits_q, sym_bits_d;
  logic [2:0] sym_len_q, sym_len_d;
  logic       sym_err_q, sym_err_d;
  logic [3:0] char_count_q, char_count_d;
  logic [6:0] slot_q [8];
  logic [6:0] slot_d [8];

  logic [CNT_W-1:0] scan_cnt_q;
  logic [2:0]       scan_idx_q;
  logic [7:0]       anode_q;
  logic [6:0]       out_q;

  logic [6:0] wr_val;
  logic [2:0] del_idx;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= COLLECT;
      sym_bits_q   <= '0;
      sym_len_q    <= '0;
      sym_err_q    <= 1'b0;
      char_count_q <= '0;
      for (int i = 0; i < 8; i++) slot_q[i] <= BLANK;
    end else begin
      state_q      <= state_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      sym_err_q    <= sym_err_d;
      char_count_q <= char_count_d;
      for (int i = 0; i < 8; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    sym_err_d    = sym_err_q;
    char_count_d = char_count_q;
    for (int i = 0; i < 8; i++) slot_d[i] = slot_q[i];
    // Unknown codes are shown as a lone g segment so the user sees a miss.
    wr_val  = (glyph == BLANK) ? DASH : glyph;
    del_idx = 3'(char_count_q - 4'd1);

    unique case (state_q)
      COLLECT: begin
        // One pulse per cycle: bksp > commit > dash > dot.
        if (bksp_pulse) begin
          if (sym_len_q != 3'd0) begin
            sym_len_d  = '0;
            sym_bits_d = '0;
            sym_err_d  = 1'b0;
          end else if (char_count_q != 4'd0) begin
            slot_d[del_idx] = BLANK;
            char_count_d    = char_count_q - 4'd1;
          end
        end else if (commit_pulse) begin
          if (sym_len_q != 3'd0) state_d = DECODE;
        end else if (dash_pulse || dot_pulse) begin
          if (sym_len_q < 3'(MAX_SYM)) begin
            for (int i = 0; i < 5; i++) begin
              if (sym_len_q == 3'(i)) sym_bits_d[i] = dash_pulse;
            end
            sym_len_d = sym_len_q + 3'd1;
          end else begin
            sym_err_d = 1'b1;
          end
        end
      end

      DECODE: begin
        // Pulses are dropped here; only the decoder response matters.
        if (decode_ack) begin
          if (char_count_q < 4'd8) begin
            slot_d[char_count_q[2:0]] = wr_val;
            char_count_d              = char_count_q + 4'd1;
          end else begin
            // A full buffer starts a fresh line rather than refusing input.
            for (int i = 1; i < 8; i++) slot_d[i] = BLANK;
            slot_d[0]    = wr_val;
            char_count_d = 4'd1;
          end
          sym_bits_d = '0;
          sym_len_d  = '0;
          sym_err_d  = 1'b0;
          state_d    = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  // --------------------------------------------------------------- scan
  // anode/out are registered from the current index, so they trail an
  // index change (or a buffer write) by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      anode_q    <= 8'h7F;
      out_q      <= BLANK;
    end else begin
      if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        scan_idx_q <= scan_idx_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
      anode_q <= ~(8'h80 >> scan_idx_q);
      out_q   <= slot_q[scan_idx_q];
    end
  end

  assign decode_req = (state_q == DECODE);
  assign busy       = (state_q == DECODE);
  assign sym_bits   = sym_bits_q;
  assign sym_len    = sym_len_q;
  assign sym_err    = sym_err_q;
  assign char_count = char_count_q;
  assign anode      = anode_q;
  assign out        = out_q;

endmodule
